// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   localparam int UART_DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_START = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Increment modulo n; n need not be a power of two.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module uart_tx_arbiter_rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] j;

   // Scan from the farthest offset down so the nearest candidate overwrites last.
   always_comb begin
      pick = '0;
      idx  = '0;
      j    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % N);
         if (req[j]) begin
            pick    = '0;
            pick[j] = 1'b1;
            idx     = j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmit byte path between
// N_REQ requesters; one tx_start per byte, waits for tx_busy to drain.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int DW      = UART_DW,
   parameter int LOCK_TO = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*DW-1:0] req_data,
   input  logic [N_REQ-1:0]    req_last,
   output logic [N_REQ-1:0]    req_ready,
   input  logic                cts,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [DW-1:0]       tx_din,
   output logic [N_REQ-1:0]    grant,
   output logic                lock_drop
);

   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(LOCK_TO);

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    owner;
   logic [IW-1:0]    nxt_ptr;
   logic [IW-1:0]    pick_idx;
   logic [N_REQ-1:0] pick_oh;
   logic [TW-1:0]    timer;
   logic             last_q;
   logic             own_valid;
   logic             hs;
   logic [DW-1:0]    own_data;

   uart_tx_arbiter_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req  (req_valid),
      .ptr  (ptr),
      .pick (pick_oh),
      .idx  (pick_idx)
   );

   assign own_valid = req_valid[owner];
   assign own_data  = req_data[owner*DW +: DW];
   assign hs        = (state == ST_ISSUE) && own_valid && cts && !tx_busy;
   assign nxt_ptr   = IW'(wrap_inc(int'(owner), N_REQ));

   always_comb begin
      req_ready        = '0;
      req_ready[owner] = hs;
   end

   // Timer never passes LOCK_TO-1: reaching it releases the lock, so it saturates by construction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         owner     <= '0;
         timer     <= '0;
         last_q    <= 1'b0;
         grant     <= '0;
         tx_start  <= 1'b0;
         tx_din    <= '0;
         lock_drop <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         lock_drop <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  grant <= pick_oh;
                  owner <= pick_idx;
                  timer <= '0;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (hs) begin
                  tx_din   <= own_data;
                  tx_start <= 1'b1;
                  last_q   <= req_last[owner];
                  timer    <= '0;
                  state    <= ST_START;
               end else if (own_valid) begin
                  timer <= '0;
               end else if (cts) begin
                  if (timer == TW'(LOCK_TO - 1)) begin
                     lock_drop <= 1'b1;
                     grant     <= '0;
                     ptr       <= nxt_ptr;
                     timer     <= '0;
                     state     <= ST_IDLE;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            ST_START: state <= ST_DRAIN;
            ST_DRAIN: begin
               if (!tx_busy) begin
                  if (last_q) begin
                     grant <= '0;
                     ptr   <= nxt_ptr;
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
